// File: rtl/ysyx_22050039_ctrl_pkg.sv
// Shared state encoding and halt reasons for the multi-cycle core controller.
package ysyx_22050039_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT_INST = 3'd1,
    S_DECODE    = 3'd2,
    S_MEM_REQ   = 3'd3,
    S_MEM_WAIT  = 3'd4,
    S_WB        = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_INVALID = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

endpackage

// File: rtl/ysyx_22050039_ctrl_wdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one, so the owner can give up in that same cycle.
module ysyx_22050039_Wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = en && (cnt_q >= W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ysyx_22050039_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, optional memory access,
// write-back, with per-handshake watchdog and cycle/retire counters.
module ysyx_22050039_ctrl
  import ysyx_22050039_pkg::*;
#(
  parameter int INST_LEN = 32,
  parameter int XLEN     = 64,
  parameter int REG_SEL  = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ifu_req_valid,
  input  logic                ifu_req_ready,
  input  logic                ifu_rsp_valid,
  input  logic [INST_LEN-1:0] ifu_rsp_inst,
  output logic [INST_LEN-1:0] inst,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                is_ebreak,
  input  logic                is_invalid,
  input  logic [REG_SEL-1:0]  rd,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  output logic                pc_wen,
  output logic                reg_wen,
  output logic                halt,
  output logic [1:0]          halt_code,
  output logic [XLEN-1:0]     cycle_cnt,
  output logic [XLEN-1:0]     instret_cnt
);

  state_e              state_q;
  logic [INST_LEN-1:0] inst_q;
  logic                store_q;
  logic                rd_nz_q;
  logic [1:0]          halt_code_q;
  logic [XLEN-1:0]     cycle_q;
  logic [XLEN-1:0]     instret_q;

  logic wd_en, wd_clr, wd_expired, hs_done;

  assign wd_en = (state_q == S_FETCH) || (state_q == S_WAIT_INST) ||
                 (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);

  assign hs_done = ((state_q == S_FETCH)     && ifu_req_ready) ||
                   ((state_q == S_WAIT_INST) && ifu_rsp_valid) ||
                   ((state_q == S_MEM_REQ)   && mem_req_ready) ||
                   ((state_q == S_MEM_WAIT)  && mem_rsp_valid);

  // Clear on every exit so each waiting state starts its budget from zero.
  assign wd_clr = hs_done || wd_expired ||
                  (state_q == S_DECODE) || (state_q == S_WB);

  ysyx_22050039_Wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      inst_q      <= '0;
      store_q     <= 1'b0;
      rd_nz_q     <= 1'b0;
      halt_code_q <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + XLEN'(1);
      case (state_q)
        S_FETCH: begin
          if (ifu_req_ready) state_q <= S_WAIT_INST;
          else if (wd_expired) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_TIMEOUT;
          end
        end
        S_WAIT_INST: begin
          if (ifu_rsp_valid) begin
            inst_q  <= ifu_rsp_inst;
            state_q <= S_DECODE;
          end else if (wd_expired) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_TIMEOUT;
          end
        end
        S_DECODE: begin
          store_q <= is_store;
          rd_nz_q <= (rd != '0);
          if (is_ebreak) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_EBREAK;
          end else if (is_invalid) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_INVALID;
          end else if (is_load || is_store) begin
            state_q <= S_MEM_REQ;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) state_q <= S_MEM_WAIT;
          else if (wd_expired) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_TIMEOUT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_rsp_valid) state_q <= S_WB;
          else if (wd_expired) begin
            state_q     <= S_HALT;
            halt_code_q <= HALT_TIMEOUT;
          end
        end
        S_WB: begin
          instret_q <= instret_q + XLEN'(1);
          state_q   <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Reset parks the FSM in FETCH; the request itself waits for release.
  assign ifu_req_valid = (state_q == S_FETCH) && !rst;
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_we    = (state_q == S_MEM_REQ) && store_q;
  assign pc_wen        = (state_q == S_WB);
  assign reg_wen       = (state_q == S_WB) && !store_q && rd_nz_q;
  assign halt          = (state_q == S_HALT);
  assign halt_code     = halt_code_q;
  assign inst          = inst_q;
  assign cycle_cnt     = cycle_q;
  assign instret_cnt   = instret_q;

endmodule

// File: doc/ysyx_22050039_ctrl.md
YSYX_22050039_CTRL -- requirements
Module: ysyx_22050039_CTRL

Interface
REQ-001 SHALL have parameter INST_LEN, default 32, instruction width.
REQ-002 SHALL have parameter XLEN, default 64, counter width.
REQ-003 SHALL have parameter REG_SEL, default 5, register index width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles on any handshake.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port ifu_req_valid  out  1  fetch request.
REQ-008 SHALL have port ifu_req_ready  in  1  fetch request accepted.
REQ-009 SHALL have port ifu_rsp_valid  in  1  fetched instruction present.
REQ-010 SHALL have port ifu_rsp_inst  in  INST_LEN  fetched instruction.
REQ-011 SHALL have port inst  out  INST_LEN  latched instruction driven to the decoder.
REQ-012 SHALL have ports is_load, is_store, is_ebreak, is_invalid  in  1 each  decoder flags for inst.
REQ-013 SHALL have port rd  in  REG_SEL  destination register index from the decoder.
REQ-014 SHALL have ports mem_req_valid / mem_req_we  out  1 each  data request / write flag.
REQ-015 SHALL have ports mem_req_ready / mem_rsp_valid  in  1 each  data request accepted / data response.
REQ-016 SHALL have ports pc_wen / reg_wen  out  1 each  PC and GPR write enables.
REQ-017 SHALL have ports halt  out  1 and halt_code  out  2  stop flag (0 ebreak, 1 invalid, 2 timeout).
REQ-018 SHALL have ports cycle_cnt / instret_cnt  out  XLEN each  cycle and retired-instruction counters.

Function
REQ-019 SHALL implement FSM states FETCH, WAIT_INST, DECODE, MEM_REQ, MEM_WAIT, WB, HALT.
REQ-020 FETCH: ifu_req_valid=1, held until ifu_req_ready; then WAIT_INST.
REQ-021 WAIT_INST: on ifu_rsp_valid, capture ifu_rsp_inst into inst; then DECODE; ifu_rsp_valid ignored in all other states.
REQ-022 inst SHALL change only on the WAIT_INST capture edge.
REQ-023 DECODE (exactly 1 cycle), priority: is_ebreak -> HALT code 0; else is_invalid -> HALT code 1; else is_load|is_store -> MEM_REQ; else WB.
REQ-024 MEM_REQ: mem_req_valid=1, mem_req_we=is_store, both held until mem_req_ready; then MEM_WAIT.
REQ-025 MEM_WAIT: on mem_rsp_valid -> WB.
REQ-026 WB (exactly 1 cycle): pc_wen=1; reg_wen=1 iff !is_store and rd!=0; instret_cnt+1; then FETCH.
REQ-027 pc_wen and reg_wen SHALL be 0 outside WB; handshake outputs 0 outside their state.
REQ-028 HALT SHALL be absorbing until rst; halt=1, halt_code held.
REQ-029 Watchdog SHALL count cycles spent in FETCH, WAIT_INST, MEM_REQ and MEM_WAIT, clearing on every state change.
REQ-030 When the watchdog reaches TIMEOUT without the awaited handshake -> HALT code 2; a handshake completing in that same cycle wins.
REQ-031 cycle_cnt SHALL increment each cycle not in HALT and wrap modulo 2^XLEN; instret_cnt likewise wraps.
REQ-032 Non-halting instruction latency: 4 cycles minimum without memory access (FETCH, WAIT_INST, DECODE, WB), 6 cycles minimum with memory access.

Reset
REQ-033 rst SHALL asynchronously force state FETCH; inst, counters, watchdog, and halt_code all 0; all outputs 0 except ifu_req_valid, which becomes 1 after release.
REQ-034 rst asserted mid-transaction SHALL abandon it; no pc_wen/reg_wen pulse is emitted.

Structure
REQ-035 State encoding and halt-code constants SHALL reside in shared package ysyx_22050039_pkg.
REQ-036 Watchdog SHALL be sub-module ysyx_22050039_Wdog (inputs: clr, en; output: expired).

Verification
REQ-037 Sequence: addi x1 (0x00100093), ready/rsp immediate -> pc_wen and reg_wen pulse in cycle 4; instret_cnt=1.
REQ-038 Sequence: store, then mem_req_ready delayed 3 cycles -> mem_req_we=1 held 4 cycles; WB has reg_wen=0; instret_cnt=1.
REQ-039 Sequence: rd=0 non-memory instruction -> pc_wen=1, reg_wen=0.
REQ-040 Sequence: ebreak (0x00100073) -> halt=1, halt_code=0; cycle_cnt frozen; no pc_wen.
REQ-041 Sequence: ifu_rsp_valid never asserted, TIMEOUT=8 -> halt_code=2 after 8 WAIT_INST cycles; with rsp in cycle 8, proceeds to DECODE instead.
REQ-042 Sequence: rst pulse during MEM_WAIT -> state FETCH, counters 0, no write-enable pulse.
